lc3_memaccess_ctrl: RTL

Sequencer for the LC3 MemAccess stage. Accepts one memory-access command (LD/LDR, LDI, ST/STR, STI) from the pipeline controller. Drives the mem_state / m_control encoding consumed by the memaccess datapath and issues the data-memory read/write strobes, including the two-step indirect accesses. Sits between the controller and the data memory, and supplies the memaccess agent's m_control, mem_state and dmem_dout view.

---
 rtl/lc3_memaccess_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lc3_memaccess_ctrl.sv
// LC3 MemAccess sequencer: drives mem_state/m_control and data-memory strobes for LD/LDI/ST/STI.
// Optional per-phase wait-state timeout is compiled in by defining MEMACCESS_TIMEOUT_EN.
module lc3_memaccess_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    input  logic [DATA_W-1:0] dmem_dout,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_din,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic [1:0]        mem_state,
    output logic              m_control,
    output logic [DATA_W-1:0] memout,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_READ_IND, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [1:0] MS_READ     = 2'd0;
    localparam logic [1:0] MS_READ_IND = 2'd1;
    localparam logic [1:0] MS_WRITE    = 2'd2;
    localparam logic [1:0] MS_IDLE     = 2'd3;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t r_state;
    logic   r_store;

`ifdef MEMACCESS_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] r_wait;
    logic              r_err;

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // dmem_addr doubles as the indirect pointer: it is loaded from dmem_dout when READ_IND completes.
    // NOTE: every registered output is assigned with <= so all of them update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_store   <= 1'b0;
            mem_state <= MS_IDLE;
            m_control <= 1'b0;
            dmem_rd   <= 1'b0;
            dmem_wr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dmem_addr <= '0;
            dmem_din  <= '0;
            memout    <= '0;
`ifdef MEMACCESS_TIMEOUT_EN
            r_wait    <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        m_control <= op[0];
                        r_store   <= op[1];
                        dmem_addr <= m_addr;
                        if (op[1]) dmem_din <= m_data;
`ifdef MEMACCESS_TIMEOUT_EN
                        r_wait    <= '0;
                        r_err     <= 1'b0;
`endif
                        if (op[0]) begin
                            r_state   <= S_READ_IND;
                            mem_state <= MS_READ_IND;
                            dmem_rd   <= 1'b1;
                        end else if (op[1]) begin
                            r_state   <= S_WRITE;
                            mem_state <= MS_WRITE;
                            dmem_wr   <= 1'b1;
                        end else begin
                            r_state   <= S_READ;
                            mem_state <= MS_READ;
                            dmem_rd   <= 1'b1;
                        end
                    end
                end
                S_READ_IND, S_READ, S_WRITE: begin
                    if (dmem_ready) begin
`ifdef MEMACCESS_TIMEOUT_EN
                        r_wait <= '0;
`endif
                        if (r_state == S_READ_IND) begin
                            dmem_addr <= ADDR_W'(dmem_dout);
                            if (r_store) begin
                                r_state   <= S_WRITE;
                                mem_state <= MS_WRITE;
                                dmem_rd   <= 1'b0;
                                dmem_wr   <= 1'b1;
                            end else begin
                                r_state   <= S_READ;
                                mem_state <= MS_READ;
                            end
                        end else begin
                            if (r_state == S_READ) memout <= dmem_dout;
                            r_state   <= S_DONE;
                            mem_state <= MS_IDLE;
                            dmem_rd   <= 1'b0;
                            dmem_wr   <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
`ifdef MEMACCESS_TIMEOUT_EN
                    else if (r_wait == WAIT_LAST) begin
                        r_state   <= S_DONE;
                        mem_state <= MS_IDLE;
                        dmem_rd   <= 1'b0;
                        dmem_wr   <= 1'b0;
                        done      <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    m_control <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
